fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register and replaces the bare PC/adder/instruction-memory path.
- Owns the fetch PC and issues one request at a time to instruction memory over a req/ack handshake.
- Buffers returned instructions with their next-PC in a small prefetch FIFO, which the decode side drains with valid/ready.
- A branch redirect from the EX/MEM stage flushes the FIFO and restarts fetch at the target address.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_queue.sv | 160 ++++++++++++++++
 tb/tb_fetch_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: FSM state, word width and FIFO entry.
// Imported by fetch_fifo and fetch_queue.
package fetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrop
    } fq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, next-PC} entries; head is read combinationally from storage.
// Clear empties the queue in one cycle and takes priority over push and pop.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  fq_entry_t                push_data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output fq_entry_t                head_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    fq_entry_t       mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !clear_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues one memory request at a time and buffers results.
// Optional perf counters (flush_cnt_o, drop_cnt_o) are built when FETCH_QUEUE_PERF_EN is defined.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   mem_req_o,
    output logic [XLEN-1:0]        mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [XLEN-1:0]        mem_rdata_i,
    input  logic                   redirect_valid_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [XLEN-1:0]        id_ir_o,
    output logic [XLEN-1:0]        id_npc_o,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [15:0]            flush_cnt_o,
    output logic [15:0]            drop_cnt_o,
`endif
    output logic [$clog2(DEPTH):0] fq_count_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    fq_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;

    logic [CntW-1:0] count;
    logic            full;
    logic            xfer;
    logic            push;
    logic            pop;
    logic            discard;
    fq_entry_t       push_data;
    fq_entry_t       head;

    assign full = (count == CntW'(DEPTH));

    // rst_n gates issue so mem_req is low while reset is held, yet the first
    // request still goes out in the cycle reset is released.
    always_comb begin
        mem_req_o = 1'b0;
        unique case (state_q)
            StIdle:         mem_req_o = rst_n && !full && !redirect_valid_i;
            StWait, StDrop: mem_req_o = 1'b1;
            default:        mem_req_o = 1'b0;
        endcase
    end

    assign mem_addr_o = (state_q == StDrop) ? drop_addr_q : pc_q;
    assign xfer       = mem_req_o && mem_ack_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        push        = 1'b0;
        discard     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                end else if (xfer) begin
                    push = 1'b1;
                    pc_d = pc_q + PC_STEP;
                end else if (mem_req_o) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                    if (mem_ack_i) begin
                        discard = 1'b1;
                        state_d = StIdle;
                    end else begin
                        // Keep the in-flight address on the bus until memory answers.
                        drop_addr_d = pc_q;
                        state_d     = StDrop;
                    end
                end else if (mem_ack_i) begin
                    push    = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = StIdle;
                end
            end
            StDrop: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                end
                if (mem_ack_i) begin
                    discard = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    assign push_data.ir  = mem_rdata_i;
    assign push_data.npc = pc_q + PC_STEP;
    assign pop           = id_valid_o && id_ready_i && !redirect_valid_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .clear_i     (redirect_valid_i),
        .count_o     (count),
        .head_o      (head)
    );

    assign id_valid_o = (count != '0);
    assign id_ir_o    = head.ir;
    assign id_npc_o   = head.npc;
    assign fq_count_o = count;

`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] flush_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (redirect_valid_i && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 1'b1;
            if (discard && drop_cnt_q != 16'hFFFF)           drop_cnt_q  <= drop_cnt_q + 1'b1;
        end
    end

    assign flush_cnt_o = flush_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`else
    // Perf counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: zero-wait and 3-cycle-latency memory, stalls, redirects, reset.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_npc;
    logic [2:0]  fq_count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0] flush_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Memory model: mode 0 acks in the request cycle, mode 1 acks on the 3rd request cycle.
    int         mem_mode = 0;
    logic [1:0] lat_q = '0;

    always #5 clk = ~clk;

    assign mem_ack   = (mem_mode == 0) ? mem_req : (mem_req && lat_q == 2'd2);
    assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

    always_ff @(posedge clk) begin
        lat_q <= (mem_req && !mem_ack) ? lat_q + 2'd1 : 2'd0;
    end

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_req_o        (mem_req),
        .mem_addr_o       (mem_addr),
        .mem_ack_i        (mem_ack),
        .mem_rdata_i      (mem_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .id_valid_o       (id_valid),
        .id_ready_i       (id_ready),
        .id_ir_o          (id_ir),
        .id_npc_o         (id_npc),
`ifdef FETCH_QUEUE_PERF_EN
        .flush_cnt_o      (flush_cnt),
        .drop_cnt_o       (drop_cnt),
`endif
        .fq_count_o       (fq_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_ir", id_ir, 0);
        check("rst_id_npc", id_npc, 0);
        check("rst_count", fq_count, 0);

        // Zero-wait streaming
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1_req0", mem_req, 1);
        check("t1_addr0", mem_addr, 32'h0);
        check("t1_valid0", id_valid, 0);
        tick();
        check("t1_valid1", id_valid, 1);
        check("t1_ir0", id_ir, 32'hA5A5_0000);
        check("t1_npc0", id_npc, 32'h4);
        check("t1_count", fq_count, 1);
        check("t1_addr4", mem_addr, 32'h4);
        tick();
        check("t1_ir1", id_ir, 32'hA5A5_0004);
        check("t1_npc1", id_npc, 32'h8);
        check("t1_count_pp", fq_count, 1);
        check("t1_addr8", mem_addr, 32'h8);

        // Stall until full
        id_ready = 1'b0;
        repeat (10) tick();
        check("t2_full", fq_count, 4);
        check("t2_req_off", mem_req, 0);
        check("t2_addr", mem_addr, 32'h14);
        check("t2_head_ir", id_ir, 32'hA5A5_0004);
        id_ready = 1'b1;
        #1;
        check("t2_req_still_off", mem_req, 0);
        tick();
        id_ready = 1'b0;
        #1;
        check("t2_count3", fq_count, 3);
        check("t2_req_on", mem_req, 1);
        check("t2_addr_again", mem_addr, 32'h14);
        check("t2_head_npc", id_npc, 32'hC);
        tick();
        check("t2_refull", fq_count, 4);

        // Redirect in IDLE with 3 entries
        id_ready = 1'b1;
        tick();
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("t3_count3", fq_count, 3);
        check("t3_req_forced_low", mem_req, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t3_flushed", fq_count, 0);
        check("t3_valid0", id_valid, 0);
        check("t3_addr", mem_addr, 32'h100);
        check("t3_req", mem_req, 1);
        tick();
        check("t3_valid1", id_valid, 1);
        check("t3_ir", id_ir, 32'hA5A5_0100);
        check("t3_npc", id_npc, 32'h104);

        // 3-cycle memory, redirect on the first WAIT cycle
        mem_mode = 1;
        id_ready = 1'b1;
        tick();
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        check("t4_wait_req", mem_req, 1);
        check("t4_wait_addr", mem_addr, 32'h104);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4_drop_req", mem_req, 1);
        check("t4_drop_addr", mem_addr, 32'h104);
        check("t4_drop_valid", id_valid, 0);
        tick();
        check("t4_no_stale", id_valid, 0);
        check("t4_new_addr", mem_addr, 32'h200);
        check("t4_new_req", mem_req, 1);
        repeat (3) tick();
        check("t4_valid", id_valid, 1);
        check("t4_ir", id_ir, 32'hA5A5_0200);
        check("t4_npc", id_npc, 32'h204);
        check("t4_count", fq_count, 1);

        // Redirect coinciding with ack in WAIT
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #1;
        check("t5_ack_cycle", mem_ack, 1);
        check("t5_addr", mem_addr, 32'h204);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t5_count", fq_count, 0);
        check("t5_valid", id_valid, 0);
        check("t5_addr_new", mem_addr, 32'h300);
        check("t5_req", mem_req, 1);
`ifdef FETCH_QUEUE_PERF_EN
        check("perf_flush", flush_cnt, 3);
        check("perf_drop", drop_cnt, 2);
`endif

        // Asynchronous reset in the middle of a WAIT
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_req", mem_req, 0);
        check("t6_addr", mem_addr, 32'h0);
        check("t6_count", fq_count, 0);
        check("t6_valid", id_valid, 0);
        check("t6_ir", id_ir, 0);
        check("t6_npc", id_npc, 0);
`ifdef FETCH_QUEUE_PERF_EN
        check("t6_perf_flush", flush_cnt, 0);
        check("t6_perf_drop", drop_cnt, 0);
`endif
        mem_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_restart_req", mem_req, 1);
        check("t6_restart_addr", mem_addr, 32'h0);
        tick();
        check("t6_restart_ir", id_ir, 32'hA5A5_0000);
        check("t6_restart_npc", id_npc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
